vload_packer: RTL and testbench

VLOAD_PACKER -- requirements
Module: vload_packer

---
 rtl/vload_packer.sv | 116 +++++++++++
 tb/tb_vload_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vload_packer.sv
// vload_packer: turns one vector-load command into NBEATS word reads, packs the
// returned beats (beat 0 in the low slice) and writes the packed vector to the
// register file in a single WRITE cycle.
module vload_packer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4,
    parameter int BEAT_WIDTH = 32,
    parameter int NBEATS     = DATA_WIDTH / BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_vreg,
    input  logic [31:0]           cmd_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [31:0]           mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [BEAT_WIDTH-1:0] mem_rsp_data,
    output logic                  vrf_we,
    output logic [ADDR_WIDTH-1:0] vrf_addr,
    output logic [DATA_WIDTH-1:0] vrf_data,
    output logic                  busy,
    output logic                  done
);
    // Counters must reach NBEATS itself, hence the +1.
    localparam int CNT_W = $clog2(NBEATS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      req_cnt, rsp_cnt;
    logic [ADDR_WIDTH-1:0] vreg_q;
    logic [31:0]           base_q;
    logic [DATA_WIDTH-1:0] vec_q, vec_nxt;
    logic                  cmd_hs, req_hs, rsp_acc, last_rsp;

    assign cmd_hs   = cmd_valid & cmd_ready;
    assign req_hs   = mem_req_valid & mem_req_ready;
    // A beat is only taken if it answers a request already issued for this load.
    assign rsp_acc  = (state == FETCH) && mem_rsp_valid &&
                      (rsp_cnt < req_cnt) && (rsp_cnt < CNT_W'(NBEATS));
    assign last_rsp = rsp_acc && (rsp_cnt == CNT_W'(NBEATS - 1));

    // Address only depends on latched base and req_cnt, so it is stable under stall.
    assign mem_req_addr = base_q + {{(32-CNT_W-2){1'b0}}, req_cnt, 2'b00};

    // Next-state and control outputs.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        mem_req_valid = 1'b0;
        vrf_we        = 1'b0;
        done          = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = FETCH;
            end
            FETCH: begin
                mem_req_valid = (req_cnt < CNT_W'(NBEATS));
                if (last_rsp) state_nxt = WRITE;
            end
            WRITE: begin
                vrf_we    = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Merge the accepted beat into its slice of the vector.
    always_comb begin
        vec_nxt = vec_q;
        if (rsp_acc) vec_nxt[BEAT_WIDTH*int'(rsp_cnt) +: BEAT_WIDTH] = mem_rsp_data;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Command latch, counters, packing and the held register-file outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vreg_q   <= '0;
            base_q   <= '0;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
            vec_q    <= '0;
            vrf_data <= '0;
            vrf_addr <= '0;
        end else begin
            if (cmd_hs) begin
                vreg_q  <= cmd_vreg;
                base_q  <= cmd_addr & ~32'h3;
                req_cnt <= '0;
                rsp_cnt <= '0;
            end else if (state == FETCH) begin
                if (req_hs)  req_cnt <= req_cnt + 1'b1;
                if (rsp_acc) rsp_cnt <= rsp_cnt + 1'b1;
            end
            vec_q <= vec_nxt;
            // Loaded on the edge into WRITE so the outputs are valid during WRITE
            // and simply hold afterwards.
            if (last_rsp) begin
                vrf_data <= vec_nxt;
                vrf_addr <= vreg_q;
            end
        end
    end
endmodule

// File: tb/tb_vload_packer.sv
// Scoreboard bench for vload_packer: expected request addresses and register
// writes are queued at command acceptance and compared as the DUT emits them.
module tb_vload_packer;
    localparam int DW = 128;
    localparam int AW = 4;
    localparam int BW = 32;
    localparam int NB = DW / BW;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          cmd_valid = 0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_vreg = '0;
    logic [31:0]   cmd_addr = '0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1;
    logic [31:0]   mem_req_addr;
    logic          mem_rsp_valid = 0;
    logic [BW-1:0] mem_rsp_data = '0;
    logic          vrf_we;
    logic [AW-1:0] vrf_addr;
    logic [DW-1:0] vrf_data;
    logic          busy;
    logic          done;

    vload_packer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vreg(cmd_vreg), .cmd_addr(cmd_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_data(vrf_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // scoreboard
    logic [31:0]   q_addr[$];
    logic [AW-1:0] q_wr_addr[$];
    logic [DW-1:0] q_wr_data[$];
    logic [BW-1:0] bd[NB];
    logic [DW-1:0] last_data;
    logic [AW-1:0] last_addr;

    int  cmd_cyc = 0, we_cyc = 0, cmd_hs = 0, we_cnt = 0, hs_idx = 0, rsp_seen = 0;
    bit  lat_chk = 0, after_done_chk = 0, force_rsp = 0, extra_rsp = 0, extra_pend = 0;
    bit  nxt_v = 0;
    logic [BW-1:0] nxt_d = '0;

    // Monitor: sample away from the active edge, compare against the scoreboard.
    always @(negedge clk) begin
        nxt_v = 0;
        if (rst_n) begin
            if (cmd_valid && busy) chk("rdy_busy", DW'(cmd_ready), DW'(0));
            if (cmd_valid && cmd_ready) begin
                logic [31:0]   b;
                logic [DW-1:0] v;
                if (after_done_chk) chk("cmd_after_done", DW'(cyc - we_cyc), DW'(1));
                cmd_cyc = cyc;
                cmd_hs++;
                hs_idx = 0;
                b = cmd_addr & ~32'h3;
                for (int k = 0; k < NB; k++) q_addr.push_back(b + 32'(4 * k));
                for (int k = 0; k < NB; k++) v[BW*k +: BW] = bd[k];
                q_wr_addr.push_back(cmd_vreg);
                q_wr_data.push_back(v);
            end
            if (mem_req_valid && mem_req_ready) begin
                if (q_addr.size() == 0) chk("unexp_req", DW'(1), DW'(0));
                else chk("req_addr", DW'(mem_req_addr), DW'(q_addr.pop_front()));
                if (lat_chk && hs_idx == 0) chk("req_lat", DW'(cyc - cmd_cyc), DW'(1));
                nxt_v = 1;
                nxt_d = (hs_idx < NB) ? bd[hs_idx] : 32'hBAD0BAD0;
                hs_idx++;
            end else if (mem_req_valid && q_addr.size() != 0) begin
                chk("stall_addr", DW'(mem_req_addr), DW'(q_addr[0]));
            end
            if (done !== vrf_we) chk("done_eq_we", DW'(done), DW'(vrf_we));
            if (vrf_we) begin
                we_cnt++;
                we_cyc = cyc;
                if (q_wr_addr.size() == 0) chk("unexp_we", DW'(1), DW'(0));
                else begin
                    last_addr = q_wr_addr.pop_front();
                    last_data = q_wr_data.pop_front();
                    chk("vrf_addr", DW'(vrf_addr), DW'(last_addr));
                    chk("vrf_data", vrf_data, last_data);
                end
                if (lat_chk) chk("we_lat", DW'(cyc - cmd_cyc), DW'(6));
            end
            if (mem_rsp_valid) rsp_seen++;
        end
    end

    // Memory model: one-cycle response latency, plus injected spurious beats.
    always @(posedge clk) begin
        #1;
        mem_rsp_valid = nxt_v | force_rsp | extra_pend;
        mem_rsp_data  = nxt_v ? nxt_d : 32'hDEADBEEF;
        extra_pend    = extra_rsp && nxt_v && (hs_idx == NB);
    end

    task automatic wait_cmd_hs(input int n);
        int t = 0;
        while (cmd_hs < n && t < 100) begin @(negedge clk); t++; end
        if (cmd_hs < n) chk("timeout_cmd", DW'(cmd_hs), DW'(n));
    endtask

    task automatic wait_we(input int n);
        int t = 0;
        while (we_cnt < n && t < 100) begin @(negedge clk); t++; end
        if (we_cnt < n) chk("timeout_we", DW'(we_cnt), DW'(n));
    endtask

    task automatic send_cmd(input logic [AW-1:0] v, input logic [31:0] a);
        int n;
        n = cmd_hs + 1;
        @(posedge clk); #1;
        cmd_vreg = v; cmd_addr = a; cmd_valid = 1;
        wait_cmd_hs(n);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic spur(input int n);
        force_rsp = 1;
        repeat (n) @(posedge clk);
        #2 force_rsp = 0;
    endtask

    task automatic hold_chk();
        repeat (3) @(negedge clk);
        chk("vrf_data_hold", vrf_data, last_data);
        chk("vrf_addr_hold", DW'(vrf_addr), DW'(last_addr));
        chk("idle_we", DW'(vrf_we), DW'(0));
    endtask

    initial begin
        int w0, r0;
        // reset state
        #12;
        chk("rst_cmd_ready", DW'(cmd_ready), DW'(1));
        chk("rst_req_valid", DW'(mem_req_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_we", DW'(vrf_we), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_vrf_data", vrf_data, DW'(0));
        chk("rst_vrf_addr", DW'(vrf_addr), DW'(0));
        #11 rst_n = 1;

        // basic load with latency checks
        bd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        lat_chk = 1;
        w0 = we_cnt;
        send_cmd(4'd5, 32'h100);
        wait_we(w0 + 1);
        lat_chk = 0;
        chk("basic_data", last_data, 128'h44444444_33333333_22222222_11111111);
        hold_chk();

        // backpressure after the first request
        bd = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        w0 = we_cnt;
        send_cmd(4'd2, 32'h100);
        begin
            int t = 0;
            while (hs_idx < 1 && t < 50) begin @(negedge clk); t++; end
        end
        @(posedge clk); #1 mem_req_ready = 0;
        repeat (3) @(posedge clk);
        #1 mem_req_ready = 1;
        wait_we(w0 + 1);
        chk("bp_req_total", DW'(hs_idx), DW'(NB));
        hold_chk();
        chk("bp_single_we", DW'(we_cnt - w0), DW'(1));

        // misaligned base with 32-bit wrap
        bd = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        w0 = we_cnt;
        send_cmd(4'd9, 32'hFFFFFFFB);
        wait_we(w0 + 1);
        hold_chk();

        // spurious beats: in IDLE, in FETCH before any request, and after the last
        spur(2);
        hold_chk();
        bd = '{32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003, 32'h5A5A0004};
        w0 = we_cnt;
        extra_rsp = 1;
        mem_req_ready = 0;
        send_cmd(4'd6, 32'h40);
        spur(1);
        #1 mem_req_ready = 1;
        wait_we(w0 + 1);
        hold_chk();
        extra_rsp = 0;
        chk("spur_single_we", DW'(we_cnt - w0), DW'(1));

        // command held during a busy load with a changed vreg
        bd = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        w0 = we_cnt;
        r0 = cmd_hs;
        @(posedge clk); #1;
        cmd_vreg = 4'd7; cmd_addr = 32'h300; cmd_valid = 1;
        wait_cmd_hs(r0 + 1);
        @(posedge clk); #1;
        cmd_vreg = 4'd9; cmd_addr = 32'h400;
        after_done_chk = 1;
        wait_cmd_hs(r0 + 2);
        @(posedge clk); #1 cmd_valid = 0;
        after_done_chk = 0;
        wait_we(w0 + 2);
        hold_chk();

        // reset in the middle of FETCH, then a fresh load to vreg 3
        bd = '{32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004};
        r0 = rsp_seen;
        send_cmd(4'd1, 32'h200);
        begin
            int t = 0;
            while (rsp_seen < r0 + 2 && t < 50) begin @(negedge clk); t++; end
            if (rsp_seen < r0 + 2) chk("timeout_rsp", DW'(rsp_seen - r0), DW'(2));
        end
        @(posedge clk); #2 rst_n = 0;
        q_addr.delete(); q_wr_addr.delete(); q_wr_data.delete();
        w0 = we_cnt;
        #1;
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_req", DW'(mem_req_valid), DW'(0));
        chk("mid_rst_we", DW'(vrf_we), DW'(0));
        chk("mid_rst_data", vrf_data, DW'(0));
        chk("mid_rst_addr", DW'(vrf_addr), DW'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        repeat (8) @(negedge clk);
        chk("no_aborted_we", DW'(we_cnt - w0), DW'(0));
        bd = '{32'h31313131, 32'h32323232, 32'h33333333, 32'h34343434};
        send_cmd(4'd3, 32'h500);
        wait_we(w0 + 1);
        chk("rst_new_vreg", DW'(last_addr), DW'(3));
        hold_chk();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
